// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Stall/flush controller for the five-stage pipeline, with action
//            state, saturating event counters and a freeze watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int WDOG_CYCLES = 1024,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_ren,
  input  logic             ex_redirect,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic             pc_stall,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_stall,
  output logic             mem_stall,
  output logic             if_flush,
  output logic             id_flush,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err_timeout
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_BUBBLE = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_FREEZE = 2'd3;

  // One extra bit so the run length can sit at WDOG_CYCLES without wrapping.
  localparam int              FR_W     = $clog2(WDOG_CYCLES) + 1;
  localparam logic [FR_W-1:0] WDOG_LIM = FR_W'(WDOG_CYCLES);
  localparam logic [FR_W-1:0] FR_ONE   = FR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic            freeze;
  logic            load_use;
  logic [1:0]      action;
  logic [FR_W-1:0] freeze_run;

  assign freeze   = icache_stall | dcache_stall;
  assign load_use = ex_mem_ren && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // Current-cycle action; reset forces RUN so the pipeline sees no controls.
  always_comb begin
    action = S_RUN;
    if (!rst_n)           action = S_RUN;
    else if (freeze)      action = S_FREEZE;
    else if (ex_redirect) action = S_FLUSH;
    else if (load_use)    action = S_BUBBLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_o <= S_RUN;
    else        state_o <= action;
  end

  always_comb begin
    pc_stall  = 1'b0;
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    case (action)
      S_FREEZE: begin
        pc_stall  = 1'b1;
        if_stall  = 1'b1;
        id_stall  = 1'b1;
        ex_stall  = 1'b1;
        mem_stall = 1'b1;
      end
      S_FLUSH: begin
        if_flush = 1'b1;
        id_flush = 1'b1;
      end
      S_BUBBLE: begin
        pc_stall = 1'b1;
        if_stall = 1'b1;
        id_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (action == S_FREEZE && stall_cnt != '1)  stall_cnt  <= stall_cnt + CNT_ONE;
      if (action == S_BUBBLE && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_ONE;
      if (action == S_FLUSH && flush_cnt != '1)   flush_cnt  <= flush_cnt + CNT_ONE;
    end
  end

  // Watchdog: flag is raised on the edge where the run length hits the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      freeze_run  <= '0;
      err_timeout <= 1'b0;
    end else if (action == S_FREEZE) begin
      if (freeze_run != WDOG_LIM)           freeze_run  <= freeze_run + FR_ONE;
      if (freeze_run >= WDOG_LIM - FR_ONE)  err_timeout <= 1'b1;
    end else begin
      freeze_run <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed plus random stimulus for hazard_ctrl against a
//            rule-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int WDOG = 4;
  localparam int CW   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_mem_ren, ex_redirect;
  logic          icache_stall, dcache_stall;
  logic          pc_stall, if_stall, id_stall, ex_stall, mem_stall;
  logic          if_flush, id_flush;
  logic [1:0]    state_o;
  logic [CW-1:0] stall_cnt, bubble_cnt, flush_cnt;
  logic          err_timeout;

  hazard_ctrl #(.WDOG_CYCLES(WDOG), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_ren(ex_mem_ren), .ex_redirect(ex_redirect),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .pc_stall(pc_stall), .if_stall(if_stall), .id_stall(id_stall),
    .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush),
    .state_o(state_o), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: plain integers, updated per cycle from the rules.
  int m_state = 0, m_stall = 0, m_bubble = 0, m_flush = 0, m_run = 0;
  int m_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int ref_action();
    bit lu;
    lu = ex_mem_ren && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!rst_n)                        return 0;
    if (icache_stall || dcache_stall)  return 3;
    if (ex_redirect)                   return 2;
    if (lu)                            return 1;
    return 0;
  endfunction

  // {pc, if, id, ex, mem stalls, if_flush, id_flush}
  function automatic logic [6:0] ref_ctrl(input int a);
    case (a)
      3:       return 7'b11111_00;
      2:       return 7'b00000_11;
      1:       return 7'b11000_01;
      default: return 7'b00000_00;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v + 1 > MAXC) ? MAXC : v + 1;
  endfunction

  // Inputs are already applied; check comb outputs, clock, then registered state.
  task automatic step();
    int a;
    #1;
    a = ref_action();
    chk("ctrl", {pc_stall, if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush},
        ref_ctrl(a));
    @(posedge clk);
    if (!rst_n) begin
      m_state = 0; m_stall = 0; m_bubble = 0; m_flush = 0; m_run = 0; m_err = 0;
    end else begin
      m_state = a;
      if (a == 3) m_stall  = sat(m_stall);
      if (a == 1) m_bubble = sat(m_bubble);
      if (a == 2) m_flush  = sat(m_flush);
      m_run = (a == 3) ? m_run + 1 : 0;
      if (m_run >= WDOG) m_err = 1;
    end
    #1;
    chk("state_o", state_o, m_state);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("bubble_cnt", bubble_cnt, m_bubble);
    chk("flush_cnt", flush_cnt, m_flush);
    chk("err_timeout", err_timeout, m_err);
  endtask

  task automatic idle();
    rst_n = 1'b1; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_ren = 0; ex_redirect = 0;
    icache_stall = 0; dcache_stall = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    step();
    chk("reset_state", state_o, 0);
    rst_n = 1'b1;

    // Load-use then release
    ex_mem_ren = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #1;
    chk("lu_ctrl", {pc_stall, if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush},
        7'b11000_01);
    step();
    chk("lu_state", state_o, 1);
    chk("lu_bubble", bubble_cnt, 1);
    ex_mem_ren = 0;
    step();

    // Redirect and load-use together
    do_reset();
    ex_mem_ren = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1; ex_redirect = 1;
    step();
    chk("redir_lu_flush", flush_cnt, 1);
    chk("redir_lu_bubble", bubble_cnt, 0);

    // dcache freeze with pending redirect
    do_reset();
    ex_redirect = 1; dcache_stall = 1;
    repeat (3) step();
    dcache_stall = 0;
    step();
    ex_redirect = 0;
    chk("frz_stall_cnt", stall_cnt, 3);
    chk("frz_flush_cnt", flush_cnt, 1);
    step();

    // x0 destination and unused source
    do_reset();
    ex_mem_ren = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    step();
    ex_rd = 7; id_rs1 = 1; id_rs2 = 7; id_use_rs2 = 0;
    step();
    chk("x0_bubble", bubble_cnt, 0);

    // Watchdog
    do_reset();
    icache_stall = 1;
    repeat (3) step();
    chk("wdog_early", err_timeout, 0);
    step();
    chk("wdog_set", err_timeout, 1);
    icache_stall = 0;
    repeat (2) step();
    chk("wdog_sticky", err_timeout, 1);

    // Saturation then reset
    do_reset();
    dcache_stall = 1;
    repeat (9) step();
    chk("sat_stall", stall_cnt, 7);
    do_reset();
    chk("rst_stall", stall_cnt, 0);
    chk("rst_err", err_timeout, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst_n        = ($urandom_range(0, 49) != 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      ex_mem_ren   = 1'($urandom_range(0, 1));
      ex_redirect  = ($urandom_range(0, 5) == 0);
      icache_stall = ($urandom_range(0, 6) == 0);
      dcache_stall = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 3) == 0) begin
        icache_stall = 1'b1;  // occasional long freezes reach the watchdog
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
